// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

   localparam int unsigned PAT_W_MAX = 16;

   localparam logic [PAT_W_MAX-1:0] DEF_PATTERN = '1;
   localparam logic                 DEF_OVERLAP = 1'b1;

   // Width of the history fill counter, which counts 0..pat_w-1.
   function automatic int unsigned fill_width(input int unsigned pat_w);
      return $clog2(pat_w);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
   import seq_det_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with programmable pattern, overlap mode,
// input-valid qualifier, Mealy and registered match strobes and a match counter.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned      PAT_W       = 4,
   parameter int unsigned      CNT_W       = 8,
   parameter logic [PAT_W-1:0] RST_PATTERN = DEF_PATTERN[PAT_W-1:0],
   parameter logic             RST_OVERLAP = DEF_OVERLAP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in,
   input  logic             in_valid,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   output logic             out,
   output logic             match_q,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned        FILL_W   = fill_width(PAT_W);
   localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  pat_r;
   logic              ovl_r;

   logic              accept;
   logic              full;
   logic [PAT_W-1:0]  window;

   assign accept = in_valid && !cfg_we;
   assign full   = (fill == FILL_MAX);
   assign window = {hist, in};
   assign out    = accept && full && (window == pat_r);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         fill    <= '0;
         pat_r   <= RST_PATTERN;
         ovl_r   <= RST_OVERLAP;
         match_q <= 1'b0;
      end else begin
         match_q <= out;
         if (cfg_we) begin
            pat_r <= cfg_pattern;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
         end else if (in_valid) begin
            hist <= window[PAT_W-2:0];
            // Non-overlap restarts the window so matched bits are never reused.
            if (out && !ovl_r) begin
               fill <= '0;
            end else if (!full) begin
               fill <= fill + FILL_W'(1);
            end
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (out),
      .q       (match_cnt)
   );

endmodule
